// File: rtl/matrix_scroller.sv
// rtl/matrix_scroller.sv - column FIFO feeding a scrolling 8x8 marquee frame
module matrix_scroller #(
    parameter int DEPTH      = 8,
    parameter int TICK_DIV   = 25,
    parameter bit FILL_BLANK = 1'b1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clear,
    input  logic [7:0]    col_data,
    input  logic          col_valid,
    output logic          col_ready,
    output logic [63:0]   matdata,
    output logic [CW-1:0] fifo_count,
    output logic          step
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_pre;
    logic [63:0]   r_mat;
    logic          r_step;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_tick;
    logic          w_pop;
    logic [7:0]    w_head;

    // Ready never looks at a same-cycle pop, so a full FIFO stays closed even on a tick edge.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign col_ready = !w_full && !clear;
    assign w_push    = col_valid && col_ready;
    assign w_tick    = en && (r_pre == TW'(TICK_DIV - 1));
    assign w_pop     = w_tick && !w_empty;
    assign w_head    = r_mem[r_rp];

    assign matdata    = r_mat;
    assign fifo_count = r_count;
    assign step       = r_step;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= col_data;
        end
    end

    // Pointers, occupancy, prescaler, frame shift and the registered step pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_pre   <= '0;
            r_mat   <= '0;
            r_step  <= 1'b0;
        end else if (clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_pre   <= '0;
            r_mat   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_step <= w_tick;
            if (en) begin
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
            end
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Column 7 is the entry edge; an empty step either blanks or holds.
            if (w_tick) begin
                if (!w_empty) begin
                    r_mat <= {w_head, r_mat[63:8]};
                end else if (FILL_BLANK) begin
                    r_mat <= {8'h00, r_mat[63:8]};
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_scroller.sv
// tb/tb_matrix_scroller.sv - directed self-checking bench for matrix_scroller
module tb_matrix_scroller;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        clear;
    logic [7:0]  col_data;
    logic        col_valid;
    logic        col_ready;
    logic [63:0] matdata;
    logic [3:0]  fifo_count;
    logic        step;
    logic        col_ready_h;
    logic [63:0] matdata_h;
    logic [3:0]  fifo_count_h;
    logic        step_h;

    int n_checks = 0;
    int n_pass   = 0;

    matrix_scroller #(.DEPTH(8), .TICK_DIV(4), .FILL_BLANK(1'b1)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready),
        .matdata(matdata), .fifo_count(fifo_count), .step(step)
    );

    matrix_scroller #(.DEPTH(8), .TICK_DIV(4), .FILL_BLANK(1'b0)) dut_hold (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready_h),
        .matdata(matdata_h), .fifo_count(fifo_count_h), .step(step_h)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; clear = 1'b0; col_data = 8'h00; col_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_mat", matdata, 64'h0);
        check("rst_count", {60'h0, fifo_count}, 64'd0);
        check("rst_step", {63'h0, step}, 64'd0);
        check("rst_ready", {63'h0, col_ready}, 64'd1);
        #1 reset = 1'b0;

        en = 1'b1; col_valid = 1'b1; col_data = 8'h81;
        cyc(1);
        check("push1_count", {60'h0, fifo_count}, 64'd1);
        col_data = 8'h42;
        cyc(1);
        check("push2_count", {60'h0, fifo_count}, 64'd2);
        col_valid = 1'b0;
        cyc(1);
        check("pre_tick_step", {63'h0, step}, 64'd0);
        cyc(1);
        check("tick1_mat", matdata, 64'h8100_0000_0000_0000);
        check("tick1_step", {63'h0, step}, 64'd1);
        check("tick1_count", {60'h0, fifo_count}, 64'd1);
        cyc(1);
        check("step_one_cycle", {63'h0, step}, 64'd0);
        cyc(3);
        check("tick2_mat", matdata, 64'h4281_0000_0000_0000);
        check("tick2_step", {63'h0, step}, 64'd1);

        en = 1'b0; col_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            col_data = 8'(i);
            cyc(1);
        end
        check("full_count", {60'h0, fifo_count}, 64'd8);
        check("full_ready", {63'h0, col_ready}, 64'd0);
        en = 1'b1;
        cyc(3);
        check("full_hold_count", {60'h0, fifo_count}, 64'd8);
        cyc(1);
        check("full_pop_count", {60'h0, fifo_count}, 64'd7);
        check("full_pop_ready", {63'h0, col_ready}, 64'd1);
        check("full_pop_mat", matdata, 64'h0142_8100_0000_0000);
        cyc(1);
        check("refill_count", {60'h0, fifo_count}, 64'd8);
        col_valid = 1'b0;

        cyc(13);
        check("order_count", {60'h0, fifo_count}, 64'd5);
        check("order_mat", matdata, 64'h0403_0201_4281_0000);
        clear = 1'b1;
        #1;
        check("clear_ready", {63'h0, col_ready}, 64'd0);
        cyc(1);
        clear = 1'b0;
        check("clear_count", {60'h0, fifo_count}, 64'd0);
        check("clear_mat", matdata, 64'h0);
        check("clear_mat_hold", matdata_h, 64'h0);
        cyc(3);
        check("clear_no_step", {63'h0, step}, 64'd0);
        cyc(1);
        check("clear_step", {63'h0, step}, 64'd1);

        col_valid = 1'b1; col_data = 8'hFF;
        cyc(1);
        col_valid = 1'b0;
        cyc(3);
        check("blank_s1_mat", matdata, 64'hFF00_0000_0000_0000);
        for (int k = 2; k <= 9; k++) begin
            logic [63:0] exp_mat;
            exp_mat = 64'hFF00_0000_0000_0000 >> (8 * (k - 1));
            cyc(4);
            check($sformatf("blank_s%0d_mat", k), matdata, exp_mat);
            check($sformatf("hold_s%0d_mat", k), matdata_h, 64'hFF00_0000_0000_0000);
            check($sformatf("hold_s%0d_step", k), {63'h0, step_h}, 64'd1);
        end

        cyc(3);
        col_valid = 1'b1; col_data = 8'h5A;
        cyc(1);
        check("nobypass_mat", matdata, 64'h0);
        check("nobypass_count", {60'h0, fifo_count}, 64'd1);
        col_data = 8'h33;
        cyc(1);
        col_valid = 1'b0;
        check("pushpop_count", {60'h0, fifo_count}, 64'd2);
        cyc(3);
        check("late_mat", matdata, 64'h5A00_0000_0000_0000);
        check("late_count", {60'h0, fifo_count}, 64'd1);
        check("late_step", {63'h0, step}, 64'd1);

        reset = 1'b1;
        #2;
        check("arst_mat", matdata, 64'h0);
        check("arst_count", {60'h0, fifo_count}, 64'd0);
        check("arst_step", {63'h0, step}, 64'd0);
        check("arst_ready", {63'h0, col_ready}, 64'd1);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
